// File: rtl/deserializer_10b_if.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_10b_if
// Description : Bundle of the serial-side inputs and the parallel-side outputs
//               of deserializer_10b. "master" is the bit source / decoder side,
//               "slave" is the deserializer itself.
//               Optional feature macro: DESER_ERR_CNT_EN (adds align_err_cnt).
// Revision    : 1.0  initial release
// ============================================================================
interface deserializer_10b_if;
    logic       serial_in;
    logic       rx_en;
    logic [9:0] data_10b_out;
    logic       par_en;
    logic       locked;
    logic       comma_det;
`ifdef DESER_ERR_CNT_EN
    logic [7:0] align_err_cnt;

    modport master (
        output serial_in, rx_en,
        input  data_10b_out, par_en, locked, comma_det, align_err_cnt
    );
    modport slave (
        input  serial_in, rx_en,
        output data_10b_out, par_en, locked, comma_det, align_err_cnt
    );
`else
    modport master (
        output serial_in, rx_en,
        input  data_10b_out, par_en, locked, comma_det
    );
    modport slave (
        input  serial_in, rx_en,
        output data_10b_out, par_en, locked, comma_det
    );
`endif
endinterface
`default_nettype wire

// File: rtl/deserializer_10b.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_10b
// Description : Serial-to-parallel front end of the SerDes receive path.
//               Shifts one bit per enabled cycle, finds 10-bit word
//               boundaries by comma detection and emits aligned code groups
//               with a one-cycle par_en strobe for the downstream decoder.
//               Optional feature macro: DESER_ERR_CNT_EN -- adds an 8-bit
//               saturating count of misaligned commas seen while locked.
// Revision    : 1.0  initial release
// ============================================================================
module deserializer_10b #(
    parameter logic [9:0]  COMMA_P = 10'b0101111100,  // output bit order
    parameter logic [9:0]  COMMA_N = 10'b1010000011,  // output bit order
    parameter int unsigned ERR_MAX = 3                // valid range 1..7
) (
    input  wire logic         clk,
    input  wire logic         rst,
    deserializer_10b_if.slave bus
);

    // Error threshold narrowed to the error counter width.
    localparam logic [2:0] C_ERR_MAX = 3'(ERR_MAX);
    localparam logic [3:0] C_LAST_BIT = 4'd9;

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // Only nine history bits are kept: the tenth bit of a window is always
    // the bit arriving in the current cycle.
    logic [8:0] sr_q,        sr_d;
    logic [9:0] data_q,      data_d;
    logic       par_en_q,    par_en_d;
    logic       comma_det_q, comma_det_d;
    logic [3:0] bit_cnt_q,   bit_cnt_d;
    logic [2:0] err_cnt_q,   err_cnt_d;
    logic [0:0] state_q,     state_d;

    logic [9:0] w_win;
    logic       w_match;
    logic       w_boundary;
    logic       w_misaligned;
    logic [2:0] w_err_inc;
    logic       w_err_hit;

    // Candidate code group: oldest bit at [9], the incoming bit at [0].
    assign w_win = {sr_q, bus.serial_in};

    // A comma is only meaningful on a cycle that actually carries a bit.
    assign w_match = bus.rx_en && ((w_win == COMMA_P) || (w_win == COMMA_N));

    // Word boundary and misalignment are both decided on bit_cnt, so they
    // can never coincide.
    assign w_boundary   = bus.rx_en && (state_q == ST_LOCK) && (bit_cnt_q == C_LAST_BIT);
    assign w_misaligned = w_match && (state_q == ST_LOCK) && (bit_cnt_q != C_LAST_BIT);

    // err_cnt never exceeds ERR_MAX-1, so the increment cannot overflow.
    assign w_err_inc = err_cnt_q + 3'd1;
    assign w_err_hit = (w_err_inc >= C_ERR_MAX);

    // Next-state logic: alignment FSM, bit counter and misalignment tracking.
    always_comb begin
        sr_d        = sr_q;
        data_d      = data_q;
        par_en_d    = 1'b0;
        comma_det_d = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        state_d     = state_q;

        if (bus.rx_en) begin
            sr_d        = w_win[8:0];
            comma_det_d = w_match;

            case (state_q)
                ST_HUNT: begin
                    // Any comma defines the word boundary directly.
                    if (w_match) begin
                        data_d    = w_win;
                        par_en_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                        err_cnt_d = 3'd0;
                        state_d   = ST_LOCK;
                    end
                end

                ST_LOCK: begin
                    if (w_boundary) begin
                        data_d    = w_win;
                        par_en_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                        // A comma on the boundary confirms the alignment.
                        if (w_match) begin
                            err_cnt_d = 3'd0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (w_misaligned) begin
                            if (w_err_hit) begin
                                // Too many off-phase commas: drop lock. The
                                // current window is deliberately not reused
                                // to realign; the next comma does that.
                                state_d   = ST_HUNT;
                                bit_cnt_d = 4'd0;
                                err_cnt_d = 3'd0;
                            end else begin
                                err_cnt_d = w_err_inc;
                            end
                        end
                    end
                end

                default: begin
                    state_d   = ST_HUNT;
                    bit_cnt_d = 4'd0;
                    err_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q        <= 9'd0;
            data_q      <= 10'd0;
            par_en_q    <= 1'b0;
            comma_det_q <= 1'b0;
            bit_cnt_q   <= 4'd0;
            err_cnt_q   <= 3'd0;
            state_q     <= ST_HUNT;
        end else begin
            sr_q        <= sr_d;
            data_q      <= data_d;
            par_en_q    <= par_en_d;
            comma_det_q <= comma_det_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            state_q     <= state_d;
        end
    end

    assign bus.data_10b_out = data_q;
    assign bus.par_en       = par_en_q;
    assign bus.comma_det    = comma_det_q;
    // locked is exactly the registered FSM state, so it follows it edge for edge.
    assign bus.locked       = (state_q == ST_LOCK);

`ifdef DESER_ERR_CNT_EN
    logic [7:0] align_err_cnt_q;

    // Saturating lifetime count of misaligned commas; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_err_cnt_q <= 8'd0;
        end else if (w_misaligned && (align_err_cnt_q != 8'hFF)) begin
            align_err_cnt_q <= align_err_cnt_q + 8'd1;
        end
    end

    assign bus.align_err_cnt = align_err_cnt_q;
`endif

endmodule
`default_nettype wire
